mem_access_unit: RTL and testbench

Memory-stage data-memory access unit of the 5-stage RISC-V pipeline, sitting between the EX/MEM register and the MEM/WB register (`pipeline_MW`). For each load or store in M, it runs a req/ack transaction on the data-memory bus and formats load data into `Datamem_outM`. While a transaction is outstanding it holds the pipeline with `stallM`. It also flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access unit: one req/ack bus transaction per load/store in M, with load formatting.
// Latency: 2+N stall cycles for N bus wait states. stallM holds the pipeline until DONE. Misaligned accesses never stall.
module mem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MRM,
   input  logic        MWM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] FU_resultM,
   input  logic [31:0] WDM,
   output logic [31:0] Datamem_outM,
   output logic        stallM,
   output logic        misalignM,
   output logic        busErrM,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   rdata_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;

   logic          access;
   logic          is_byte;
   logic          is_half;
   logic          misal;
   logic          go;
   logic [3:0]    st_be;
   logic [31:0]   st_wdata;
   logic [31:0]   ld_shift;
   logic [31:0]   ld_fmt;

   // Store codes 100/101 are not byte/half stores, so they fall through to word.
   always_comb begin
      access  = MRM | MWM;
      is_byte = (funct3M == 3'b000) || (MRM && funct3M == 3'b100);
      is_half = (funct3M == 3'b001) || (MRM && funct3M == 3'b101);
      if (is_byte)
         misal = 1'b0;
      else if (is_half)
         misal = FU_resultM[0];
      else
         misal = |FU_resultM[1:0];
      go = access && !misal;

      if (is_byte) begin
         st_be    = 4'b0001 << FU_resultM[1:0];
         st_wdata = {4{WDM[7:0]}};
      end else if (is_half) begin
         st_be    = FU_resultM[1] ? 4'b1100 : 4'b0011;
         st_wdata = {2{WDM[15:0]}};
      end else begin
         st_be    = 4'b1111;
         st_wdata = WDM;
      end
   end

   always_comb begin
      ld_shift = dm_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ld_fmt = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_fmt = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_fmt = {24'b0, ld_shift[7:0]};
         3'b101:  ld_fmt = {16'b0, ld_shift[15:0]};
         default: ld_fmt = dm_rdata;
      endcase
   end

   // Reset gating keeps the combinational outputs at zero while rst is held low.
   assign stallM       = rst && ((state == IDLE && go) || state == REQ);
   assign misalignM    = rst && state == IDLE && access && misal;
   assign busErrM      = (state == REQ) && !dm_ack && (cnt == CNT_LAST);
   assign Datamem_outM = (state == DONE) ? rdata_q : 32'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rdata_q  <= '0;
         f3_q     <= '0;
         off_q    <= '0;
         dm_req   <= 1'b0;
         dm_we    <= 1'b0;
         dm_addr  <= '0;
         dm_wdata <= '0;
         dm_be    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  state    <= REQ;
                  cnt      <= '0;
                  dm_req   <= 1'b1;
                  dm_we    <= MWM;
                  dm_addr  <= {FU_resultM[31:2], 2'b00};
                  dm_be    <= MWM ? st_be : 4'b1111;
                  dm_wdata <= MWM ? st_wdata : 32'b0;
                  f3_q     <= funct3M;
                  off_q    <= FU_resultM[1:0];
               end
            end
            REQ: begin
               if (dm_ack) begin
                  rdata_q <= dm_we ? 32'b0 : ld_fmt;
                  cnt     <= '0;
                  dm_req  <= 1'b0;
                  state   <= DONE;
               end else if (cnt == CNT_LAST) begin
                  rdata_q <= 32'b0;
                  cnt     <= '0;
                  dm_req  <= 1'b0;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level timeline model and per-cycle compare.
module tb_mem_access_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MRM = 1'b0, MWM = 1'b0;
   logic [2:0]  funct3M = 3'b0;
   logic [31:0] FU_resultM = 32'b0, WDM = 32'b0;
   logic [31:0] Datamem_outM;
   logic        stallM, misalignM, busErrM;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_rdata = 32'b0;

   mem_access_unit #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .MRM(MRM), .MWM(MWM), .funct3M(funct3M),
      .FU_resultM(FU_resultM), .WDM(WDM), .Datamem_outM(Datamem_outM),
      .stallM(stallM), .misalignM(misalignM), .busErrM(busErrM),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        chk_en = 1'b0;
   logic        exp_stall, exp_req, exp_mis, exp_berr, exp_we, exp_bus, exp_wcheck;
   logic [31:0] exp_dout, exp_addr, exp_wdata;
   logic [3:0]  exp_be;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Spec-level model: access width, alignment, lane enables and load extension.
   function automatic int nbytes(input logic rd, input logic [2:0] f3);
      if (f3 == 3'd0 || (rd && f3 == 3'd4)) return 1;
      if (f3 == 3'd1 || (rd && f3 == 3'd5)) return 2;
      return 4;
   endfunction

   function automatic logic is_misaligned(input logic rd, input logic [2:0] f3, input logic [31:0] a);
      return (a % nbytes(rd, f3)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic rd, input logic [2:0] f3, input logic [31:0] a);
      int nb;
      nb = nbytes(rd, f3);
      if (rd) return 4'hF;
      return 4'(((1 << nb) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      int nb;
      nb = nbytes(1'b0, f3);
      if (nb == 1) return {4{wd[7:0]}};
      if (nb == 2) return {2{wd[15:0]}};
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      int nb;
      logic [31:0] v, mask;
      nb = nbytes(1'b1, f3);
      if (nb == 4) return w;
      v    = w >> (8 * (a % 4));
      mask = (nb == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
      v    = v & mask;
      if ((f3 == 3'd0 || f3 == 3'd1) && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
      return v;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stallM", 32'(stallM), 32'(exp_stall));
         chk("dm_req", 32'(dm_req), 32'(exp_req));
         chk("misalignM", 32'(misalignM), 32'(exp_mis));
         chk("busErrM", 32'(busErrM), 32'(exp_berr));
         chk("Datamem_outM", Datamem_outM, exp_dout);
         if (exp_bus) begin
            chk("dm_we", 32'(dm_we), 32'(exp_we));
            chk("dm_addr", dm_addr, exp_addr);
            chk("dm_be", 32'(dm_be), 32'(exp_be));
            if (exp_wcheck) chk("dm_wdata", dm_wdata, exp_wdata);
         end
      end
   end

   task automatic set_idle_exp();
      exp_stall = 0; exp_req = 0; exp_mis = 0; exp_berr = 0; exp_dout = 0;
      exp_bus = 0; exp_wcheck = 0; exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
   endtask

   task automatic idle(input int n, input logic ack);
      for (int k = 0; k < n; k++) begin
         MRM = 0; MWM = 0; dm_ack = ack; dm_rdata = 32'h1357_9BDF;
         set_idle_exp();
         chk_en = 1;
         @(posedge clk); #1;
      end
   endtask

   // One M-stage instruction. n = bus wait states (n >= TMO means no ack); rst_at = cycle to assert reset, -1 for none.
   task automatic run(input logic rd, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rdw, input int n, input logic lit_en, input logic [31:0] lit,
                      input int rst_at);
      logic mis, tmo;
      int   len, last;
      logic [31:0] res;
      mis  = is_misaligned(rd, f3, a);
      tmo  = (n >= TMO);
      len  = tmo ? TMO : n + 1;
      res  = (tmo || !rd) ? 32'b0 : m_load(f3, a, rdw);
      if (lit_en) chk("model_load", res, lit);
      last = mis ? 0 : len + 1;
      for (int k = 0; k <= last; k++) begin
         MRM = rd; MWM = !rd; funct3M = f3; FU_resultM = a; WDM = wd;
         if (k == rst_at) begin
            chk_en = 0;
            rst = 0;
            #1;
            chk("rst_dm_req", 32'(dm_req), 0);
            chk("rst_stallM", 32'(stallM), 0);
            chk("rst_dm_addr", dm_addr, 0);
            chk("rst_dm_be", 32'(dm_be), 0);
            @(posedge clk); #1;
            idle(1, 1'b0);
            rst = 1;
            return;
         end
         dm_ack     = !mis && !tmo && (k == n + 1);
         dm_rdata   = dm_ack ? rdw : (32'hA5A5_5A5A ^ 32'(k));
         exp_stall  = !mis && (k <= len);
         exp_req    = !mis && (k >= 1) && (k <= len);
         exp_mis    = mis;
         exp_berr   = tmo && (k == len);
         exp_dout   = (!mis && k == len + 1) ? res : 32'b0;
         exp_bus    = exp_req;
         exp_wcheck = !rd;
         exp_we     = !rd;
         exp_addr   = {a[31:2], 2'b00};
         exp_be     = m_be(rd, f3, a);
         exp_wdata  = m_wdata(f3, wd);
         chk_en     = 1;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_idle_exp();
      // Model pins: hand-computed store lanes and write data.
      chk("pin_sb_be", 32'(m_be(1'b0, 3'd0, 32'h201)), 32'h2);
      chk("pin_sb_wd", m_wdata(3'd0, 32'h1234_56AB), 32'hABAB_ABAB);
      chk("pin_sh_be", 32'(m_be(1'b0, 3'd1, 32'h202)), 32'hC);
      chk("pin_sh_wd", m_wdata(3'd1, 32'h1234_56AB), 32'h56AB_56AB);

      repeat (2) @(posedge clk);
      #1;
      idle(2, 1'b0);
      rst = 1;
      idle(1, 1'b0);

      run(1, 3'd2, 32'h100, 0, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, -1);
      run(1, 3'd0, 32'h103, 0, 32'h80FF_0000, 1, 1, 32'hFFFF_FF80, -1);
      run(1, 3'd4, 32'h103, 0, 32'h80FF_0000, 0, 1, 32'h0000_0080, -1);
      run(1, 3'd1, 32'h102, 0, 32'h80FF_0000, 2, 1, 32'hFFFF_80FF, -1);
      run(0, 3'd0, 32'h201, 32'h1234_56AB, 0, 0, 0, 0, -1);
      run(0, 3'd1, 32'h202, 32'h1234_56AB, 0, 1, 0, 0, -1);
      run(1, 3'd2, 32'h102, 0, 32'h1111_1111, 0, 0, 0, -1);
      run(0, 3'd2, 32'h301, 32'hCAFE_F00D, 0, 0, 0, 0, -1);
      run(1, 3'd5, 32'h101, 0, 32'h1111_1111, 0, 0, 0, -1);
      idle(2, 1'b1);
      run(1, 3'd2, 32'h104, 0, 32'h7777_7777, 99, 1, 32'h0, -1);
      idle(1, 1'b0);
      run(0, 3'd2, 32'h300, 32'hCAFE_F00D, 0, 2, 0, 0, -1);
      run(1, 3'd5, 32'h106, 0, 32'h8001_1234, 0, 1, 32'h0000_8001, -1);
      run(1, 3'd2, 32'h100, 0, 32'h2468_ACE0, 3, 0, 0, 2);
      run(1, 3'd2, 32'h108, 0, 32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D, -1);
      idle(2, 1'b0);

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
